// File: rtl/qft_spi_pkg.sv
// qft_spi_pkg: shared constants, command-byte layout and FSM states for the
// QFT SPI register bank.
package qft_spi_pkg;

    // Register map anchors
    localparam logic [5:0] OUT_BASE  = 6'h10;
    localparam logic [5:0] CTRL_ADDR = 6'h3E;
    localparam logic [5:0] STAT_ADDR = 6'h3F;

    // Command byte layout: {rw, burst, addr[5:0]}
    localparam int unsigned CMD_RW_BIT    = 7;
    localparam int unsigned CMD_BURST_BIT = 6;
    localparam int unsigned CMD_ADDR_MSB  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } spi_state_t;

    // Burst address step: wraps inside the 16-entry window, so 0x0F->0x00
    // and 0x1F->0x10.
    function automatic logic [5:0] burst_next(input logic [5:0] a);
        return {a[5:4], a[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/qft_spi_sync.sv
// qft_spi_sync: 2-FF synchronizers for the SPI pins plus sclk edge detect
// in the clk domain.
module qft_spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic cs_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    // Two synchronizing stages per pin; sclk gets a third stage for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign cs_s      = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];

endmodule

// File: rtl/qft_spi_regbank.sv
// qft_spi_regbank: SPI mode-0 slave register bank in front of the QFT core.
// Holds input amplitudes, result shadows, CTRL start and STATUS {done, busy}.
// Optional feature: define QFT_SPI_BURST_EN for burst address auto-increment.
module qft_spi_regbank
    import qft_spi_pkg::*;
#(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned N_IN   = 16,
    parameter int unsigned N_OUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    output logic [N_IN*DATA_W-1:0]  in_vec,
    output logic                    in_valid,
    input  logic [N_OUT*DATA_W-1:0] out_vec,
    input  logic                    out_valid,
    output logic                    busy
);

    logic              cs_s;
    logic              mosi_s;
    logic              sclk_rise;
    logic              sclk_fall;

    spi_state_t        state_q;
    spi_state_t        state_d;

    logic [2:0]        bit_cnt_q;
    logic [6:0]        shift_q;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_q;
    logic [7:0]        rd_byte;
    logic [5:0]        addr_q;
    logic [5:0]        rd_addr;
    logic              rd_live;
    logic              first_q;
    logic              burst_en;
    logic              data_live;
    logic              byte_done;
    logic              done_q;

    logic [DATA_W-1:0] in_regs_q [N_IN];
    logic [DATA_W-1:0] shadow_q  [N_OUT];

    qft_spi_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .cs_s      (cs_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

`ifdef QFT_SPI_BURST_EN
    logic burst_q;
    assign burst_en = burst_q;
`else
    assign burst_en = 1'b0;
`endif

    assign rx_byte   = {shift_q, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    // Only the first data byte of a frame is live unless bursting
    assign data_live = first_q | burst_en;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: cs deassertion always aborts back to IDLE
    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CMD;
                CMD:     if (byte_done) state_d = rx_byte[CMD_RW_BIT] ? RDATA : WDATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Read mux: next byte to shift out (command address, or next burst address)
    always_comb begin
        rd_addr = burst_next(addr_q);
        rd_live = burst_en;
        if (state_q == CMD) begin
            rd_addr = rx_byte[CMD_ADDR_MSB:0];
            rd_live = 1'b1;
        end
        rd_byte = '0;
        if (rd_live) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (rd_addr == 6'(i)) rd_byte[DATA_W-1:0] = in_regs_q[i];
            end
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (rd_addr == OUT_BASE + 6'(i)) rd_byte[DATA_W-1:0] = shadow_q[i];
            end
            if (rd_addr == STAT_ADDR) rd_byte = {6'b0, done_q, busy};
        end
    end

    // SPI datapath, register file, start/done/busy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            first_q   <= 1'b0;
            miso      <= 1'b0;
            in_valid  <= 1'b0;
            busy      <= 1'b0;
            done_q    <= 1'b0;
`ifdef QFT_SPI_BURST_EN
            burst_q   <= 1'b0;
`endif
            for (int unsigned i = 0; i < N_IN; i++) in_regs_q[i] <= '0;
            for (int unsigned i = 0; i < N_OUT; i++) shadow_q[i] <= '0;
        end else begin
            in_valid <= 1'b0;

            if (cs_s || state_q == IDLE) begin
                bit_cnt_q <= '0;
                miso      <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    shift_q   <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == CMD) begin
                            addr_q  <= rx_byte[CMD_ADDR_MSB:0];
                            first_q <= 1'b1;
`ifdef QFT_SPI_BURST_EN
                            burst_q <= rx_byte[CMD_BURST_BIT];
`endif
                            tx_q    <= rx_byte[CMD_RW_BIT] ? rd_byte : 8'h00;
                        end else begin
                            first_q <= 1'b0;
                            if (burst_en) addr_q <= burst_next(addr_q);
                            if (state_q == WDATA && data_live) begin
                                for (int unsigned i = 0; i < N_IN; i++) begin
                                    if (addr_q == 6'(i)) in_regs_q[i] <= rx_byte[DATA_W-1:0];
                                end
                                if (addr_q == CTRL_ADDR && rx_byte[0]) in_valid <= 1'b1;
                            end
                            if (state_q == RDATA) begin
                                if (data_live && addr_q == STAT_ADDR) done_q <= 1'b0;
                                tx_q <= rd_byte;
                            end
                        end
                    end
                end
                // Read bits leave on the fall so the master sees them by the next rise
                if (sclk_fall && state_q == RDATA) begin
                    miso <= tx_q[7];
                    tx_q <= {tx_q[6:0], 1'b0};
                end
            end

            // busy follows the start pulse, so a result arriving alongside a
            // (re)start leaves the new job marked in flight
            if (in_valid) begin
                busy <= 1'b1;
            end else if (out_valid) begin
                busy <= 1'b0;
            end

            // Placed after the STATUS clear so a coincident result keeps done set
            if (out_valid) begin
                done_q <= 1'b1;
                for (int unsigned i = 0; i < N_OUT; i++) begin
                    shadow_q[i] <= out_vec[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Flatten input registers onto the core bus
    always_comb begin
        in_vec = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_vec[i*DATA_W +: DATA_W] = in_regs_q[i];
        end
    end

endmodule

// File: tb/tb_qft_spi_regbank.sv
// tb_qft_spi_regbank: self-checking bench for qft_spi_regbank. SPI reads
// push expected bytes to a scoreboard queue and pop them as bytes arrive.
// Honours QFT_SPI_BURST_EN when choosing burst expectations.
`timescale 1ns/1ps
module tb_qft_spi_regbank;

    localparam int unsigned DATA_W   = 6;
    localparam int unsigned N_IN     = 16;
    localparam int unsigned N_OUT    = 16;
    localparam int unsigned HALF     = 8;
    localparam int unsigned CORE_LAT = 19;
`ifdef QFT_SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    sclk;
    logic                    cs;
    logic                    mosi;
    logic                    miso;
    logic [N_IN*DATA_W-1:0]  in_vec;
    logic                    in_valid;
    logic [N_OUT*DATA_W-1:0] out_vec;
    logic                    out_valid;
    logic                    busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          iv_high  = 0;
    int          iv_rises = 0;
    logic        iv_prev  = 1'b0;
    int          core_mode = 0;
    logic [5:0]  core_val  = 6'd5;
    logic [7:0]  exp_q[$];
    string       tag_q[$];

    qft_spi_regbank #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_valid pulse monitor
    always @(negedge clk) begin
        if (in_valid) iv_high++;
        if (in_valid && !iv_prev) iv_rises++;
        iv_prev = in_valid;
    end

    // Core model: mode 0 answers CORE_LAT cycles after start, mode 1 answers
    // in the start cycle itself, mode 2 never answers
    initial begin : core_model
        out_valid = 1'b0;
        out_vec   = '0;
        forever begin
            @(negedge clk);
            if (in_valid && rst_n && core_mode != 2) begin
                if (core_mode == 0) repeat (CORE_LAT) @(negedge clk);
                out_vec = '0;
                out_vec[0 +: DATA_W]      = core_val;
                out_vec[DATA_W +: DATA_W] = core_val + 6'd1;
                out_valid = 1'b1;
                @(negedge clk);
                out_valid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input logic [7:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int unsigned n, output logic [7:0] rx);
        rx = '0;
        for (int unsigned k = 0; k < n; k++) begin
            mosi = tx[7-k];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_write(input logic [5:0] addr, input logic [7:0] data);
        logic [7:0] rx;
        cs_low();
        spi_bits({2'b00, addr}, 8, rx);
        spi_bits(data, 8, rx);
        cs_high();
    endtask

    task automatic spi_read(input logic [5:0] addr, input logic burst, input int unsigned nbytes);
        logic [7:0] rx;
        cs_low();
        spi_bits({1'b1, burst, addr}, 8, rx);
        for (int unsigned b = 0; b < nbytes; b++) begin
            spi_bits(8'h00, 8, rx);
            if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else check(tag_q.pop_front(), {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end
        cs_high();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] rx;
        int r0, h0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_in_vec", in_vec, 0);
        check("rst_busy", busy, 0);
        check("rst_in_valid", in_valid, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        expect_rd("status_after_rst", 8'h00);
        spi_read(6'h3F, 1'b0, 1);

        spi_write(6'h0C, 8'd16);
        check("in_vec_reg12", in_vec[12*DATA_W +: DATA_W], 16);
        expect_rd("rd_reg12", 8'd16);
        spi_read(6'h0C, 1'b0, 1);

        // Upper bits above DATA_W are dropped
        spi_write(6'h01, 8'hFF);
        expect_rd("rd_reg1_trunc", 8'h3F);
        spi_read(6'h01, 1'b0, 1);

        // Unmapped address and CTRL read back as zero
        spi_write(6'h20, 8'h15);
        expect_rd("rd_unmapped", 8'h00);
        spi_read(6'h20, 1'b0, 1);
        expect_rd("rd_ctrl", 8'h00);
        spi_read(6'h3E, 1'b0, 1);

        // Start with delayed core response
        core_mode = 0;
        core_val  = 6'd5;
        r0 = iv_rises;
        h0 = iv_high;
        cs_low();
        spi_bits({2'b00, 6'h3E}, 8, rx);
        spi_bits(8'h01, 8, rx);
        check("start_iv_pulses", iv_rises - r0, 1);
        check("start_iv_width", iv_high - h0, 1);
        check("start_busy_set", busy, 1);
        cs_high();
        for (int k = 0; k < 200 && busy; k++) @(negedge clk);
        check("busy_clear", busy, 0);
        expect_rd("rd_shadow0", 8'd5);
        spi_read(6'h10, 1'b0, 1);
        expect_rd("rd_shadow1", 8'd6);
        spi_read(6'h11, 1'b0, 1);
        expect_rd("status_done", 8'h02);
        spi_read(6'h3F, 1'b0, 1);
        expect_rd("status_cleared", 8'h00);
        spi_read(6'h3F, 1'b0, 1);

        // cs raised mid data byte: partial write discarded
        spi_write(6'h03, 8'd5);
        cs_low();
        spi_bits({2'b00, 6'h03}, 8, rx);
        spi_bits(8'h3F, 4, rx);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_reg3", in_vec[3*DATA_W +: DATA_W], 5);
        expect_rd("abort_rd_reg3", 8'd5);
        spi_read(6'h03, 1'b0, 1);

        // Burst write from 0x0E across the 0x0F->0x00 wrap
        spi_write(6'h0F, 8'd42);
        spi_write(6'h00, 8'd7);
        cs_low();
        spi_bits({2'b01, 6'h0E}, 8, rx);
        spi_bits(8'd1, 8, rx);
        spi_bits(8'd2, 8, rx);
        spi_bits(8'd3, 8, rx);
        cs_high();
        check("burst_reg0e", in_vec[14*DATA_W +: DATA_W], 1);
        check("burst_reg0f", in_vec[15*DATA_W +: DATA_W], BURST ? 2 : 42);
        check("burst_reg00", in_vec[0 +: DATA_W], BURST ? 3 : 7);
        expect_rd("burst_rd0", 8'd1);
        expect_rd("burst_rd1", BURST ? 8'd2 : 8'd0);
        expect_rd("burst_rd2", BURST ? 8'd3 : 8'd0);
        spi_read(6'h0E, 1'b1, 3);

        // Result arrives in the same cycle as the start pulse
        core_mode = 1;
        core_val  = 6'd9;
        spi_write(6'h3E, 8'h01);
        check("same_cycle_busy", busy, 1);
        expect_rd("same_cycle_shadow", 8'd9);
        spi_read(6'h10, 1'b0, 1);
        expect_rd("same_cycle_status", 8'h03);
        spi_read(6'h3F, 1'b0, 1);
        expect_rd("same_cycle_status2", 8'h01);
        spi_read(6'h3F, 1'b0, 1);

        // Restart while busy still pulses in_valid
        core_mode = 2;
        r0 = iv_rises;
        spi_write(6'h3E, 8'h01);
        check("restart_iv", iv_rises - r0, 1);
        check("restart_busy", busy, 1);

        // Reset in the middle of a read frame of reg 0x01 (0x3F)
        cs_low();
        spi_bits({2'b10, 6'h01}, 8, rx);
        spi_bits(8'h00, 3, rx);
        repeat (4) @(negedge clk);
        check("miso_pre_rst", miso, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", miso, 0);
        check("midrst_in_vec", in_vec, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_rd("post_rst_status", 8'h00);
        spi_read(6'h3F, 1'b0, 1);
        expect_rd("post_rst_shadow", 8'h00);
        spi_read(6'h10, 1'b0, 1);

        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qft_spi_regbank.md
QFT_SPI_REGBANK -- requirements
Module: qft_spi_regbank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, meaning amplitude width (S1.4-style fixed point, 1..8).
REQ-002 The block SHALL have parameter N_IN, default 16, meaning the number of input amplitude registers (1..16).
REQ-003 The block SHALL have parameter N_OUT, default 16, meaning the number of output amplitude registers (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have ports sclk, cs, mosi (input, 1 bit each) and miso (output, 1 bit): SPI mode 0, cs active-low.
REQ-007 The block SHALL have port in_vec, output, N_IN*DATA_W bits: register i is at bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port in_valid, output, 1 bit: one-cycle start pulse to the core.
REQ-009 The block SHALL have ports out_vec (input, N_OUT*DATA_W bits) and out_valid (input, 1 bit): core result and qualifier.
REQ-010 The block SHALL have port busy, output, 1 bit: a job is in flight.

Function
REQ-011 sclk, cs and mosi SHALL pass through a 2-FF synchronizer; sclk edges SHALL be detected in clk; sclk period is at least 4 clk periods.
REQ-012 The frame SHALL be: command byte {rw, burst, addr[5:0]}, MSB first, then one or more data bytes; data is right-justified and the upper 8-DATA_W bits are written as zero and ignored.
REQ-013 The FSM SHALL have states IDLE, CMD, WDATA and RDATA; cs low moves IDLE->CMD; the 8th bit moves to WDATA (rw=0) or RDATA (rw=1).
REQ-014 mosi SHALL be sampled on the detected sclk rise; miso SHALL update after the detected sclk fall, with the first read bit driven before the first data rise.
REQ-015 The address map SHALL be: 0x00..N_IN-1 input regs (R/W); 0x10..0x10+N_OUT-1 output shadow regs (RO); 0x3E CTRL (bit0 write-1 = start); 0x3F STATUS {done, busy} in bits [1:0]; all other addresses read 0, writes to them are ignored.
REQ-016 A write SHALL commit on the 8th data bit of each data byte.
REQ-017 A CTRL start SHALL pulse in_valid for exactly one cycle in the cycle after commit and set busy.
REQ-018 out_valid SHALL capture out_vec into the shadow regs, clear busy and set the sticky done flag.
REQ-019 A STATUS read SHALL clear done after the byte completes.
REQ-020 If a start and out_valid occur in the same cycle, the block SHALL capture the result and set done, and busy SHALL remain 1.
REQ-021 A start while busy=1 SHALL still pulse in_valid (the core restarts).
REQ-022 cs rising mid-byte SHALL discard the partial byte, return the FSM to IDLE and leave all registers unchanged.

Reset
REQ-023 rst_n low SHALL clear all input regs, shadow regs, done, busy, in_valid and the FSM (to IDLE), and drive miso to 0, immediately and regardless of any SPI activity.

Configuration
REQ-024 With QFT_SPI_BURST_EN defined, burst=1 SHALL auto-increment the address after each data byte while cs stays low, wrapping 0x0F->0x00 and 0x1F->0x10.
REQ-025 Without QFT_SPI_BURST_EN, the burst bit SHALL be ignored and data bytes after the first in a frame SHALL be discarded (writes) or read as 0 (reads).

Structure
REQ-026 Package qft_spi_pkg SHALL hold OUT_BASE=0x10, CTRL_ADDR=0x3E, STAT_ADDR=0x3F, the command bit positions and the FSM state enum.
REQ-027 Sub-module qft_spi_sync SHALL implement the 2-FF synchronizer and the sclk rise/fall detect.

Verification
REQ-028 Reset, then read 0x3F -> 0x00; in_vec = 0; miso = 0.
REQ-029 Write 16 to 0x0C, then read 0x0C -> 16; in_vec[12*6 +: 6] = 16.
REQ-030 Write 0x01 to 0x3E -> in_valid high for exactly 1 cycle, then busy=1; a model core returns out_valid after 19 cycles with out_vec[0]=5 -> busy=0; read 0x10 -> 5; read 0x3F -> 0x02; read 0x3F again -> 0x00.
REQ-031 Raise cs after 4 data bits of a write of 0x3F to 0x03 -> register 0x03 unchanged; next frame decodes correctly.
REQ-032 (QFT_SPI_BURST_EN) Burst write starting at 0x0E with values 1,2,3 -> regs 0x0E=1, 0x0F=2, 0x00=3; without the macro only 0x0E=1 is written.
REQ-033 Assert out_valid in the same cycle as the start pulse -> shadow updated, done=1, busy=1.
